// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and mode constants for the interval timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } timer_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_if.sv
// rtl/timer_ctrl_if.sv - control and status bundle between a host and the interval timer
interface timer_ctrl_if #(parameter int N = 8);

  logic         cfg_we;
  logic [N-1:0] cfg_period;
  logic         cfg_mode;
  logic         start;
  logic         pause;
  logic         stop;
  logic [N-1:0] count;
  logic         tick;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output cfg_we, cfg_period, cfg_mode, start, pause, stop,
    input  count, tick, busy, done, err
  );

  modport slave (
    input  cfg_we, cfg_period, cfg_mode, start, pause, stop,
    output count, tick, busy, done, err
  );

endinterface

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - N-bit up-counter with synchronous clear and count enable
module tick_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - interval timer FSM: config registers, terminal compare, tick and err strobes
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  timer_ctrl_if.slave  bus
);

  timer_state_t state, state_nxt;
  logic [N-1:0] period_reg;
  logic         mode_reg;
  logic [N-1:0] count;
  logic [N-1:0] term_val;
  logic         at_term;
  logic         cnt_clr, cnt_en;
  logic         tick_nxt, err_nxt;
  logic         tick_q, err_q;

  assign term_val = period_reg - 1'b1;
  assign at_term  = (count == term_val);

  tick_counter #(.N(N)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // HOLD with pause released advances on that same edge, so the tick slips by exactly the held cycles.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    tick_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (bus.cfg_we && (state != IDLE)) begin
      err_nxt = 1'b1;
    end
    if (bus.stop) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
    end else if (bus.start) begin
      if ((state == IDLE) && (period_reg == '0)) begin
        err_nxt = 1'b1;
      end else begin
        state_nxt = RUN;
        cnt_clr   = 1'b1;
      end
    end else begin
      case (state)
        RUN, HOLD: begin
          if (bus.pause) begin
            state_nxt = HOLD;
          end else if (at_term) begin
            cnt_clr   = 1'b1;
            tick_nxt  = 1'b1;
            state_nxt = (mode_reg == MODE_PERIODIC) ? RUN : DONE;
          end else begin
            cnt_en    = 1'b1;
            state_nxt = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_reg <= '0;
      mode_reg   <= MODE_ONESHOT;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.cfg_we) begin
        period_reg <= bus.cfg_period;
        mode_reg   <= bus.cfg_mode;
      end
      tick_q <= tick_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.count = count;
  assign bus.tick  = tick_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state == RUN) || (state == HOLD);
  assign bus.done  = (state == DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - self-checking bench for timer_ctrl using a tick-cycle scoreboard
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  timer_ctrl_if #(.N(N)) bus ();

  timer_ctrl #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [N-1:0] p, input logic m);
    bus.cfg_we = 1'b1;
    bus.cfg_period = p;
    bus.cfg_mode = m;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    bus.cfg_we = 0; bus.cfg_period = '0; bus.cfg_mode = 0;
    bus.start = 0; bus.pause = 0; bus.stop = 0;
    reset_n = 1'b0;
    step(); step();
    total++;
    if ({bus.count, bus.tick, bus.busy, bus.done, bus.err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %b, expected all zero", {bus.count, bus.tick, bus.busy, bus.done, bus.err});
    end
    reset_n = 1'b1;
    step();
    total++;
    if ({bus.count, bus.tick, bus.busy, bus.done, bus.err} !== '0) begin
      bad++; $display("FAIL reset_release: got %b, expected all zero", {bus.count, bus.tick, bus.busy, bus.done, bus.err});
    end
  endtask

  task automatic test_periodic();
    int e;
    exp_q.delete();
    do_cfg(8'd5, MODE_PERIODIC);
    pulse_start();
    exp_q.push_back(5); exp_q.push_back(10); exp_q.push_back(15);
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) step();
      if (bus.tick === 1'b1) begin
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (e != c) begin bad++; $display("FAIL periodic_tick: tick at cycle %0d, expected cycle %0d", c, e); end
      end
      total++;
      if (bus.count !== 8'(c % 5) || bus.busy !== 1'b1) begin
        bad++; $display("FAIL periodic_count: cycle %0d count=%0d busy=%b, expected count=%0d busy=1", c, bus.count, bus.busy, c % 5);
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL periodic_missing: %0d ticks not seen, expected 0", exp_q.size()); end
    pulse_stop();
    total++;
    if ({bus.busy, bus.count, bus.tick} !== '0) begin
      bad++; $display("FAIL periodic_stop: busy=%b count=%0d tick=%b, expected 0/0/0", bus.busy, bus.count, bus.tick);
    end
  endtask

  task automatic test_oneshot();
    int e;
    exp_q.delete();
    do_cfg(8'd3, MODE_ONESHOT);
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      exp_q.push_back(3);
      for (int c = 0; c <= 5; c++) begin
        if (c > 0) step();
        if (bus.tick === 1'b1) begin
          total++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          if (e != c) begin bad++; $display("FAIL oneshot_tick: round %0d tick at cycle %0d, expected cycle %0d", r, c, e); end
        end
        total++;
        if (bus.count !== 8'((c < 3) ? c : 0) || bus.busy !== (c < 3) || bus.done !== (c >= 3)) begin
          bad++; $display("FAIL oneshot_state: round %0d cycle %0d count=%0d busy=%b done=%b, expected count=%0d busy=%b done=%b",
                          r, c, bus.count, bus.busy, bus.done, (c < 3) ? c : 0, c < 3, c >= 3);
        end
      end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL oneshot_missing: round %0d, %0d ticks not seen, expected 0", r, exp_q.size()); end
    end
    pulse_stop();
  endtask

  task automatic test_pause();
    int e;
    int exp_cnt[12] = '{0, 1, 2, 2, 2, 2, 3, 0, 1, 2, 3, 0};
    exp_q.delete();
    do_cfg(8'd4, MODE_PERIODIC);
    pulse_start();
    exp_q.push_back(7); exp_q.push_back(11);
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) step();
      if (bus.tick === 1'b1) begin
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (e != c) begin bad++; $display("FAIL pause_tick: tick at cycle %0d, expected cycle %0d", c, e); end
      end
      total++;
      if (bus.count !== 8'(exp_cnt[c]) || bus.busy !== 1'b1) begin
        bad++; $display("FAIL pause_count: cycle %0d count=%0d busy=%b, expected count=%0d busy=1", c, bus.count, bus.busy, exp_cnt[c]);
      end
      if (c == 2) bus.pause = 1'b1;
      if (c == 5) bus.pause = 1'b0;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL pause_missing: %0d ticks not seen, expected 0", exp_q.size()); end
    pulse_stop();
  endtask

  task automatic test_pause_terminal();
    int e;
    int exp_cnt[9] = '{0, 1, 2, 2, 2, 0, 1, 2, 0};
    exp_q.delete();
    do_cfg(8'd3, MODE_PERIODIC);
    pulse_start();
    exp_q.push_back(5); exp_q.push_back(8);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step();
      if (bus.tick === 1'b1) begin
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (e != c) begin bad++; $display("FAIL pause_term_tick: tick at cycle %0d, expected cycle %0d", c, e); end
      end
      total++;
      if (bus.count !== 8'(exp_cnt[c])) begin
        bad++; $display("FAIL pause_term_count: cycle %0d count=%0d, expected %0d", c, bus.count, exp_cnt[c]);
      end
      if (c == 2) bus.pause = 1'b1;
      if (c == 4) bus.pause = 1'b0;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL pause_term_missing: %0d ticks not seen, expected 0", exp_q.size()); end
    pulse_stop();
  endtask

  task automatic test_err();
    int e;
    exp_q.delete();
    do_cfg(8'd0, MODE_PERIODIC);
    pulse_start();
    total++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL err_p0: err=%b busy=%b done=%b, expected 1/0/0", bus.err, bus.busy, bus.done);
    end
    step();
    total++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL err_p0_clear: err=%b busy=%b, expected 0/0", bus.err, bus.busy);
    end
    do_cfg(8'd4, MODE_PERIODIC);
    pulse_start();
    exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(12);
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) step();
      if (bus.tick === 1'b1) begin
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (e != c) begin bad++; $display("FAIL err_run_tick: tick at cycle %0d, expected cycle %0d", c, e); end
      end
      total++;
      if (bus.err !== (c == 2) || bus.count !== 8'(c % 4)) begin
        bad++; $display("FAIL err_run: cycle %0d err=%b count=%0d, expected err=%b count=%0d", c, bus.err, bus.count, c == 2, c % 4);
      end
      if (c == 1) begin bus.cfg_we = 1'b1; bus.cfg_period = 8'd9; bus.cfg_mode = MODE_ONESHOT; end
      if (c == 2) bus.cfg_we = 1'b0;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL err_run_missing: %0d ticks not seen, expected 0", exp_q.size()); end
    pulse_stop();
  endtask

  task automatic test_stop_start();
    do_cfg(8'd4, MODE_PERIODIC);
    pulse_start();
    step(); step(); step();
    total++;
    if (bus.count !== 8'd3) begin bad++; $display("FAIL stop_start_pre: count=%0d, expected 3", bus.count); end
    bus.stop = 1'b1; bus.start = 1'b1;
    step();
    bus.stop = 1'b0; bus.start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({bus.busy, bus.count, bus.tick, bus.done} !== '0) begin
        bad++; $display("FAIL stop_start: cycle %0d busy=%b count=%0d tick=%b done=%b, expected all 0", c, bus.busy, bus.count, bus.tick, bus.done);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int e;
    exp_q.delete();
    do_cfg(8'd5, MODE_PERIODIC);
    pulse_start();
    step(); step(); step();
    pulse_start();
    exp_q.push_back(5);
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) step();
      if (bus.tick === 1'b1) begin
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (e != c) begin bad++; $display("FAIL restart_tick: tick at cycle %0d, expected cycle %0d", c, e); end
      end
      total++;
      if (bus.count !== 8'(c % 5) || bus.busy !== 1'b1) begin
        bad++; $display("FAIL restart_count: cycle %0d count=%0d busy=%b, expected count=%0d busy=1", c, bus.count, bus.busy, c % 5);
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL restart_missing: %0d ticks not seen, expected 0", exp_q.size()); end
    pulse_stop();
  endtask

  task automatic test_p1();
    int e;
    exp_q.delete();
    do_cfg(8'd1, MODE_PERIODIC);
    pulse_start();
    for (int c = 1; c <= 4; c++) exp_q.push_back(c);
    for (int c = 1; c <= 4; c++) begin
      step();
      total++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      if (bus.tick !== 1'b1 || e != c || bus.count !== 8'd0) begin
        bad++; $display("FAIL p1_periodic: cycle %0d tick=%b count=%0d, expected tick=1 count=0 (scoreboard cycle %0d)", c, bus.tick, bus.count, e);
      end
    end
    pulse_stop();
    do_cfg(8'd1, MODE_ONESHOT);
    pulse_start();
    step();
    total++;
    if (bus.tick !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 8'd0) begin
      bad++; $display("FAIL p1_oneshot: tick=%b done=%b busy=%b count=%0d, expected 1/1/0/0", bus.tick, bus.done, bus.busy, bus.count);
    end
    pulse_stop();
  endtask

  task automatic test_reset_mid();
    do_cfg(8'd10, MODE_PERIODIC);
    pulse_start();
    for (int c = 0; c < 6; c++) step();
    total++;
    if (bus.count !== 8'd6) begin bad++; $display("FAIL reset_mid_pre: count=%0d, expected 6", bus.count); end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.count, bus.tick, bus.busy, bus.done, bus.err} !== '0) begin
      bad++; $display("FAIL reset_mid_async: got %b, expected all zero", {bus.count, bus.tick, bus.busy, bus.done, bus.err});
    end
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      total++;
      if ({bus.tick, bus.busy, bus.count} !== '0) begin
        bad++; $display("FAIL reset_mid_idle: cycle %0d tick=%b busy=%b count=%0d, expected 0/0/0", c, bus.tick, bus.busy, bus.count);
      end
    end
    // period was cleared by reset, so a bare start must be refused
    pulse_start();
    total++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_start: err=%b busy=%b, expected 1/0", bus.err, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_pause();
    test_pause_terminal();
    test_err();
    test_stop_start();
    test_back_to_back();
    test_p1();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Programmable interval timer controller that sequences an N-bit up-counter: loads a period, starts, pauses, stops, and reports terminal-count ticks.
- Supports one-shot and periodic modes.
- Sits between a control/register interface and any block needing periodic strobes, e.g. display refresh, debounce sampling or baud ticks.

Parameters:
N, 8, width of period and count values

Ports:
clk  in  1  system clock, all state changes on rising edge
reset_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe, honoured only in IDLE
cfg_period  in  N  terminal period P, in clk cycles
cfg_mode  in  1  0 = one-shot, 1 = periodic
start  in  1  start or restart request, single-cycle pulse
pause  in  1  level; freezes count while high in RUN
stop  in  1  abort to IDLE, single-cycle pulse
count  out  N  current count value
tick  out  1  registered one-cycle pulse at each terminal count
busy  out  1  high in RUN or HOLD
done  out  1  high in DONE (one-shot complete)
err  out  1  registered one-cycle pulse on an illegal request

Behaviour:
- Reset (reset_n low, async): state=IDLE, period_reg=0, mode_reg=0, count=0, tick=0, busy=0, done=0, err=0.
- Outputs are registered. busy and done decode directly from state.
- States and transitions:
  - IDLE:
    - cfg_we: period_reg<=cfg_period, mode_reg<=cfg_mode.
    - start with period_reg!=0: go to RUN, count=0.
    - start with period_reg==0: stay IDLE, err pulse.
  - RUN:
    - count increments by 1 each cycle.
    - When count==period_reg-1: next edge sets count<=0 and tick<=1.
    - Then mode_reg=0 goes to DONE; mode_reg=1 stays in RUN.
    - pause high: go to HOLD, count frozen.
  - HOLD:
    - count held.
    - pause low: return to RUN; incrementing resumes the following edge.
  - DONE:
    - count=0, done=1.
    - start: go to RUN (restart with the same config).
  - Any state, stop: go to IDLE, count<=0, tick not asserted.
- Latency:
  - First tick is asserted P cycles after the edge that samples start.
  - In periodic mode, subsequent ticks follow every P cycles, excluding cycles spent in HOLD.
- P=1: tick every cycle in periodic mode. One-shot reaches DONE one cycle after start.
- Simultaneous events, priority: reset_n > stop > start > pause > count advance.
  - stop+start in the same cycle: go to IDLE.
  - start in RUN/HOLD: restart, count<=0, state RUN, no tick.
  - pause on the terminal-count cycle: pause wins; count stays at P-1 and the tick fires on the first RUN edge after pause falls.
- cfg_we outside IDLE: ignored, period_reg and mode_reg unchanged, err pulse. Reconfiguring requires stop first.
- Arithmetic:
  - Count is N bits unsigned, compared against period_reg-1 computed in N bits.
  - Period 0 is never run, so no underflow path exists.
  - count never exceeds P-1; no natural wrap at 2^N.
- Reset asserted mid-run: all outputs clear immediately (async). Operation resumes only via a new start after reset_n deasserts.

Decomposition:
- Shared package timer_pkg:
  - enum timer_state_t {IDLE, RUN, HOLD, DONE}.
  - mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- Sub-module tick_counter (N-bit): async active-low reset, sync clear, enable; outputs count.
- timer_ctrl holds the FSM, config registers, terminal compare and the tick/err registers.

Test Plan:
- Reset, then cfg P=5 mode=1, start at cycle 0 -> tick at cycles 5, 10 and 15; count cycles 0..4; busy=1 throughout.
- cfg P=3 mode=0, start -> single tick at cycle 3, then done=1 and count=0; start again -> tick at cycle 3 after the restart.
- P=4 periodic, pause high for 3 cycles when count=2 -> count holds 2; tick delayed by exactly 3 cycles (cycle 7 instead of 4).
- start with P=0 -> err pulse for 1 cycle, state stays IDLE; cfg_we during RUN -> err pulse, period unchanged, ticks still every P.
- stop and start asserted in the same cycle during RUN at count=3 -> IDLE, count=0, no tick.
- reset_n pulled low mid-count (count=6, P=10) -> all outputs 0 asynchronously; after release, no tick until a new start.
